// File: rtl/keychain_ctrl.sv
// Byte-level command sequencer between the UART and the keychain cipher core.
// Parses 'K'/'E' frames, loads key/message, runs the core and returns result or status.
`timescale 1ns/1ps
module keychain_ctrl #(
  parameter int KEY_BYTES      = 2,
  parameter int MSG_BYTES      = 1,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [7:0]             rx_data_in,
  input  logic                   rx_valid_in,
  output logic [7:0]             tx_data_out,
  output logic                   tx_valid_out,
  input  logic                   tx_ready_in,
  output logic [8*KEY_BYTES-1:0] key_out,
  output logic                   key_valid_out,
  output logic [8*MSG_BYTES-1:0] msg_out,
  output logic                   start_out,
  input  logic [8*MSG_BYTES-1:0] result_in,
  input  logic                   done_in,
  output logic                   busy_out
);

  localparam int KW        = 8 * KEY_BYTES;
  localparam int MW        = 8 * MSG_BYTES;
  localparam int MAX_BYTES = (KEY_BYTES > MSG_BYTES) ? KEY_BYTES : MSG_BYTES;
  localparam int CNT_W     = $clog2(MAX_BYTES + 1);
  localparam int TMR_W     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CMD_KEY    = 8'h4B;
  localparam logic [7:0] CMD_ENC    = 8'h45;
  localparam logic [7:0] STATUS_ACK = 8'h06;
  localparam logic [7:0] STATUS_NAK = 8'h15;

  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BYTES - 1);
  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    RX_KEY,
    RX_MSG,
    START,
    WAIT_CORE,
    TX_RESULT,
    TX_STATUS
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [TMR_W-1:0]  timer_reg, timer_next;
  logic [KW-1:0]     key_shadow_reg, key_shadow_next;
  logic [MW-1:0]     msg_shadow_reg, msg_shadow_next;
  logic [KW-1:0]     key_reg, key_next;
  logic              key_valid_reg, key_valid_next;
  logic [MW-1:0]     msg_reg, msg_next;
  logic              start_reg, start_next;
  logic [7:0]        tx_data_reg, tx_data_next;
  logic              tx_valid_reg, tx_valid_next;
  logic [MW-1:0]     tx_shift_reg, tx_shift_next;
  logic              busy_reg, busy_next;

  logic              tx_fire;
  logic [KW-1:0]     key_shift;
  logic [MW-1:0]     msg_shift;

  // Big-endian shift-in: the oldest byte drifts up to the MS position.
  assign key_shift = KW'({key_shadow_reg, rx_data_in});
  assign msg_shift = MW'({msg_shadow_reg, rx_data_in});
  assign tx_fire   = tx_valid_reg && tx_ready_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      timer_reg      <= '0;
      key_shadow_reg <= '0;
      msg_shadow_reg <= '0;
      key_reg        <= '0;
      key_valid_reg  <= 1'b0;
      msg_reg        <= '0;
      start_reg      <= 1'b0;
      tx_data_reg    <= '0;
      tx_valid_reg   <= 1'b0;
      tx_shift_reg   <= '0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      timer_reg      <= timer_next;
      key_shadow_reg <= key_shadow_next;
      msg_shadow_reg <= msg_shadow_next;
      key_reg        <= key_next;
      key_valid_reg  <= key_valid_next;
      msg_reg        <= msg_next;
      start_reg      <= start_next;
      tx_data_reg    <= tx_data_next;
      tx_valid_reg   <= tx_valid_next;
      tx_shift_reg   <= tx_shift_next;
      busy_reg       <= busy_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    timer_next      = timer_reg;
    key_shadow_next = key_shadow_reg;
    msg_shadow_next = msg_shadow_reg;
    key_next        = key_reg;
    key_valid_next  = key_valid_reg;
    msg_next        = msg_reg;
    start_next      = 1'b0;
    tx_data_next    = tx_data_reg;
    tx_valid_next   = tx_valid_reg;
    tx_shift_next   = tx_shift_reg;

    case (state_reg)
      IDLE: begin
        cnt_next   = '0;
        timer_next = '0;
        if (rx_valid_in) begin
          if (rx_data_in == CMD_KEY) begin
            key_shadow_next = '0;
            state_next      = RX_KEY;
          end else if (rx_data_in == CMD_ENC) begin
            msg_shadow_next = '0;
            state_next      = RX_MSG;
          end else begin
            tx_data_next  = STATUS_NAK;
            tx_valid_next = 1'b1;
            state_next    = TX_STATUS;
          end
        end
      end

      RX_KEY: begin
        if (rx_valid_in) begin
          key_shadow_next = key_shift;
          timer_next      = '0;
          if (cnt_reg == KEY_LAST) begin
            key_next       = key_shift;
            key_valid_next = 1'b1;
            tx_data_next   = STATUS_ACK;
            tx_valid_next  = 1'b1;
            state_next     = TX_STATUS;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end else if (timer_reg == TMR_LAST) begin
          tx_data_next  = STATUS_NAK;
          tx_valid_next = 1'b1;
          state_next    = TX_STATUS;
        end else begin
          timer_next = timer_reg + TMR_ONE;
        end
      end

      RX_MSG: begin
        if (rx_valid_in) begin
          msg_shadow_next = msg_shift;
          timer_next      = '0;
          if (cnt_reg == MSG_LAST) begin
            // Without a committed key the message is refused and msg_out kept.
            if (key_valid_reg) begin
              msg_next   = msg_shift;
              start_next = 1'b1;
              state_next = START;
            end else begin
              tx_data_next  = STATUS_NAK;
              tx_valid_next = 1'b1;
              state_next    = TX_STATUS;
            end
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end else if (timer_reg == TMR_LAST) begin
          tx_data_next  = STATUS_NAK;
          tx_valid_next = 1'b1;
          state_next    = TX_STATUS;
        end else begin
          timer_next = timer_reg + TMR_ONE;
        end
      end

      START: begin
        state_next = WAIT_CORE;
      end

      WAIT_CORE: begin
        if (done_in) begin
          tx_data_next  = result_in[MW-1 -: 8];
          tx_shift_next = result_in << 8;
          tx_valid_next = 1'b1;
          cnt_next      = '0;
          state_next    = TX_RESULT;
        end
      end

      TX_RESULT: begin
        if (tx_fire) begin
          if (cnt_reg == MSG_LAST) begin
            tx_valid_next = 1'b0;
            state_next    = IDLE;
          end else begin
            tx_data_next  = tx_shift_reg[MW-1 -: 8];
            tx_shift_next = tx_shift_reg << 8;
            cnt_next      = cnt_reg + CNT_ONE;
          end
        end
      end

      TX_STATUS: begin
        if (tx_fire) begin
          tx_valid_next = 1'b0;
          state_next    = IDLE;
        end
      end

      default: begin
        tx_valid_next = 1'b0;
        state_next    = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign tx_data_out   = tx_data_reg;
  assign tx_valid_out  = tx_valid_reg;
  assign key_out       = key_reg;
  assign key_valid_out = key_valid_reg;
  assign msg_out       = msg_reg;
  assign start_out     = start_reg;
  assign busy_out      = busy_reg;

endmodule

// File: doc/keychain_ctrl.md
# keychain_ctrl

Byte-level command sequencer between the UART receiver/transmitter and the keychain cipher core. Parses a framed command stream from the host, loads key and message registers, pulses the core's start, waits for completion, and streams the result or a status byte back through the transmitter. Sits inside `keychain`, replacing direct UART-to-core wiring.

## Interface
- KEY_BYTES, 2, key length in bytes (≥1)
- MSG_BYTES, 1, message/result length in bytes (≥1)
- TIMEOUT_CYCLES, 1_000_000, max idle cycles between bytes of one frame (≥2)
- clk_in  input  1  system clock; single clock domain
- rst_in  input  1  reset, asynchronous, active-high
- rx_data_in  input  8  received byte
- rx_valid_in  input  1  one-cycle strobe, rx_data_in valid
- tx_data_out  output  8  byte to transmit
- tx_valid_out  output  1  tx_data_out valid; held until accepted
- tx_ready_in  input  1  transmitter accepts byte when tx_valid_out && tx_ready_in
- key_out  output  8*KEY_BYTES  committed key to core
- key_valid_out  output  1  a complete key has been committed since reset
- msg_out  output  8*MSG_BYTES  message to core
- start_out  output  1  one-cycle start pulse to core
- result_in  input  8*MSG_BYTES  core result, valid when done_in
- done_in  input  1  one-cycle core completion strobe
- busy_out  output  1  high in every state except IDLE

## Operation
- Command bytes: 0x4B 'K' = load key; 0x45 'E' = encrypt. Any other byte in IDLE → NAK.
- Status bytes: ACK = 0x06, NAK = 0x15.
- States: IDLE, RX_KEY, RX_MSG, START, WAIT_CORE, TX_RESULT, TX_STATUS.
- IDLE: on rx_valid_in, 'K' → RX_KEY, 'E' → RX_MSG, else → TX_STATUS(NAK). Byte counter and timer cleared.
- RX_KEY: shift bytes into shadow register, first byte lands in MS byte (big-endian). After KEY_BYTES bytes: key_out ← shadow, key_valid_out ← 1, → TX_STATUS(ACK).
- RX_MSG: same big-endian shift into msg shadow. After MSG_BYTES bytes: if key_valid_out, msg_out ← shadow, → START; else → TX_STATUS(NAK), msg_out unchanged.
- START: start_out = 1 for exactly this cycle, → WAIT_CORE.
- WAIT_CORE: on done_in, capture result_in into output shift register, → TX_RESULT. No core timeout.
- TX_RESULT: present MS byte first; advance on each handshake; after MSG_BYTES handshakes → IDLE.
- TX_STATUS: present status byte until handshake, → IDLE.
- Timeout: in RX_KEY/RX_MSG, timer counts cycles without rx_valid_in; reaching TIMEOUT_CYCLES → TX_STATUS(NAK), partial shadow discarded, key_out/key_valid_out/msg_out unchanged. rx_valid_in on the expiry cycle wins: byte accepted, timer cleared.
- rx_valid_in in START, WAIT_CORE, TX_RESULT, TX_STATUS: byte dropped, no effect.
- done_in outside WAIT_CORE: ignored.
- A 'K' frame that times out or completes never alters msg_out; a failed frame never alters key_out.

## Timing
- Reset: state IDLE; tx_data_out 0, tx_valid_out 0, key_out 0, key_valid_out 0, msg_out 0, start_out 0, busy_out 0; counters 0. Reset mid-frame or mid-transmit aborts immediately, key lost.
- All outputs registered.
- Last key byte strobe at cycle N → key_out, key_valid_out, tx_valid_out(0x06) at N+1.
- Last msg byte strobe at N → msg_out valid and start_out high at N+1 only; busy_out high from cycle after command byte.
- done_in at M → tx_valid_out with result MS byte at M+1.
- Handshake at P → next byte on tx_data_out at P+1 (tx_valid_out stays high); after final handshake, tx_valid_out low and state IDLE at P+1; a command byte strobed at P+1 is accepted.
- tx_ready_in high continuously → one byte per cycle.

## Test plan
- Reset then 'K',0xA5,0x3C → key_out=0xA53C, key_valid_out=1, one ACK 0x06 transmitted.
- After key load, 'E',0x7E → msg_out=0x7E, single start_out pulse one cycle after 0x7E; done_in with result_in=0xC1 → 0xC1 transmitted, back to IDLE.
- After reset, 'E',0x11 → no start_out, NAK 0x15, msg_out stays 0.
- Command byte 0x00 in IDLE → NAK 0x15; tx_ready_in held low 10 cycles → tx_data_out/tx_valid_out stable until handshake.
- TIMEOUT_CYCLES=16: 'K',0xFF then silence 16 cycles → NAK, key_out unchanged; repeat with byte on exact expiry cycle → accepted, frame completes with ACK.
- rx bytes injected during WAIT_CORE and TX_RESULT → ignored; rst_in asserted in WAIT_CORE → all outputs 0 asynchronously, later done_in ignored.
